misr_compactor_p: RTL
=====================

Name: misr_compactor_p

Overview:
Parametrised multiple-input signature register (MISR) with its own run-control FSM, for BIST response compaction.
- Compacts a programmable number of CUT response words into a WIDTH-bit signature using a configurable feedback polynomial and seed.
- Compares the result against a run-time golden signature and reports pass/fail.
- Sits between the CUT output bus and the BIST controller. It replaces fixed-width, free-running signature capture.

Parameters:
WIDTH, 74, signature and response width in bits (>=2)
POLY, (1<<73)|(1<<70)|(1<<69)|1, feedback tap mask; bit i set means sig[MSB] is XORed into stage i; bit 0 must be set
SEED, 0, value loaded into the signature on start
CNT_W, 16, width of the pattern counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a run; accepted only in IDLE or DONE
abort  in  1  cancels a run; returns to IDLE; signature retained
num_patterns  in  CNT_W  number of response words to compact; sampled on start
din  in  WIDTH  CUT response word
din_valid  in  1  din is valid this cycle
golden  in  WIDTH  expected signature; sampled in COMPARE
signature  out  WIDTH  current MISR contents
busy  out  1  high in COMPACT and COMPARE
done  out  1  high in DONE
pass  out  1  signature==golden; valid while done
fail  out  1  signature!=golden; valid while done

Behaviour:
- Reset (async, any state): state=IDLE; signature=0, cnt=0, busy=0, done=0, pass=0, fail=0.
- States: IDLE, COMPACT, COMPARE, DONE.
- IDLE/DONE + start: signature<=SEED, cnt<=num_patterns, pass<=0, fail<=0, done<=0.
  - Next state is COMPACT if num_patterns!=0, else COMPARE.
- COMPACT, din_valid=1, on each edge:
  - sig'[0] = din[0] ^ (POLY[0] & sig[W-1]).
  - sig'[i] = din[i] ^ sig[i-1] ^ (POLY[i] & sig[W-1]) for i=1..W-1.
  - cnt decrements; on the edge where cnt==1, next state is COMPARE.
- COMPACT, din_valid=0: signature and cnt hold. Gaps of any length are allowed.
- COMPARE (exactly one cycle): pass<=(signature==golden), fail<=!that, done<=1, next state DONE. Signature holds.
- DONE: all outputs hold until start, abort or reset.
- Latency: done/pass/fail are visible after the edge that follows the edge accepting the last word. With continuous din_valid, done rises N+1 edges after the start edge.
- start while busy is ignored.
- abort has priority over start and din_valid. From COMPACT/COMPARE/DONE it goes to IDLE, clears busy/done/pass/fail, and keeps the signature.
- din_valid outside COMPACT is ignored; the signature does not change.
- signature is driven directly from the register; no output latency.
- Arithmetic: cnt wraps never, because the decrement is gated at 1. num_patterns up to 2^CNT_W-1.

Decomposition:
- Package misr_pkg holds:
  - state enum (IDLE, COMPACT, COMPARE, DONE);
  - localparam DEFAULT_POLY_74 (bits 73,70,69,0);
  - a function misr_step(sig, din, poly).
- Natural sub-module: misr_core. It contains the WIDTH-bit register with load (SEED), enable (advance), async reset and the misr_step next-state logic. The FSM and counter stay in the top.

Test Plan:
1. WIDTH=8, POLY=8'h1D, SEED=0, N=2, din 8'h01 then 8'h00 back-to-back, golden=8'h02 -> signature=8'h02, done=1, pass=1, fail=0, busy low one edge after COMPARE.
2. WIDTH=8, POLY=8'h1D, SEED=8'h80, N=1, din=8'h00, golden=8'h00 -> signature=8'h1D (feedback taps), done=1, fail=1.
3. As test 1, but din_valid low for 3 cycles between the words -> signature still 8'h02; busy held through the gap; done exactly one edge after the second word.
4. N=0, SEED=8'h80 -> start goes directly to COMPARE; signature=8'h80; pass=1 iff golden=8'h80; din ignored.
5. reset asserted asynchronously mid-COMPACT (after 1 of 3 words) -> signature=0, busy=0, done=0 without a clock edge. A new start then completes normally.
6. Default WIDTH=74, N=1, din=74'h1, golden=0 -> signature=74'h1, fail=1. abort in DONE clears done/fail; signature stays 74'h1. start during busy has no effect.

Source files
------------

// File: rtl/misr_pkg.sv
// Shared types and the MISR next-state function for the BIST response compactor.
package misr_pkg;

  typedef enum logic [1:0] {IDLE, COMPACT, COMPARE, DONE} state_t;

  // Widest signature misr_step can handle; instances must keep WIDTH <= MAX_W.
  localparam int MAX_W = 256;

  localparam logic [73:0] DEFAULT_POLY_74 =
    (74'd1 << 73) | (74'd1 << 70) | (74'd1 << 69) | 74'd1;

  // Operands are zero-extended to MAX_W; width selects the live MSB used as feedback.
  function automatic logic [MAX_W-1:0] misr_step(
    input logic [MAX_W-1:0] sig,
    input logic [MAX_W-1:0] din,
    input logic [MAX_W-1:0] poly,
    input int unsigned      width
  );
    logic [MAX_W-1:0] msb;
    logic [MAX_W-1:0] mask;
    msb  = {{(MAX_W-1){1'b0}}, 1'b1} << (width - 1);
    mask = (msb << 1) - {{(MAX_W-1){1'b0}}, 1'b1};
    return ((sig << 1) ^ din ^ (((sig & msb) != '0) ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register: loads SEED, advances one MISR step when enabled, clears on reset.
module misr_core
  import misr_pkg::*;
#(
  parameter int               WIDTH = 74,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY_74),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_advance,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_sig
);

  logic [WIDTH-1:0] r_sig;
  logic [WIDTH-1:0] w_next;

  assign w_next = WIDTH'(misr_step(MAX_W'(r_sig), MAX_W'(i_din), MAX_W'(POLY), WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (i_load) begin
      r_sig <= SEED;
    end else if (i_advance) begin
      r_sig <= w_next;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/misr_compactor_p.sv
// MISR response compactor with run-control FSM: seed, compact N words, compare to golden.
module misr_compactor_p
  import misr_pkg::*;
#(
  parameter int               WIDTH = 74,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY_74),
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;

  logic             w_start_ok;
  logic             w_advance;
  logic             w_match;
  logic [WIDTH-1:0] w_sig;

  // abort outranks both start and din_valid, so it gates the core controls too.
  assign w_start_ok = start & ~abort & ((r_state == IDLE) | (r_state == DONE));
  assign w_advance  = ~abort & din_valid & (r_state == COMPACT);
  assign w_match    = (w_sig == golden);

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk       (clk),
    .rst       (reset),
    .i_load    (w_start_ok),
    .i_advance (w_advance),
    .i_din     (din),
    .o_sig     (w_sig)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else if (abort) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_cnt   <= num_patterns;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_state <= (num_patterns != '0) ? COMPACT : COMPARE;
          end
        end
        COMPACT: begin
          if (din_valid) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
              r_state <= COMPARE;
            end
          end
        end
        COMPARE: begin
          r_pass  <= w_match;
          r_fail  <= ~w_match;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign signature = w_sig;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;

endmodule
